// File: rtl/lfsr_stream_checker.sv
// lfsr_stream_checker: locks onto a 6-bit Fibonacci LFSR stream (s[k+6]=s[k]^s[k+1]), flags mismatches and loss of sync.
// Define LFSR_CHK_ERRCNT_EN to build the saturating err_count; otherwise it reads as zero.
module lfsr_stream_checker #(
  parameter int LOCK_CNT = 12,
  parameter int LOSS_WIN = 16,
  parameter int LOSS_ERR = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       locked,
  output logic       err_pulse,
  output logic       sync_lost,
  output logic [7:0] err_count
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_WIN + 1);
  localparam int EW = $clog2(LOSS_ERR + 1);
  localparam logic [MW-1:0] LOCK_V = MW'(LOCK_CNT);
  localparam logic [BW-1:0] WIN_V = BW'(LOSS_WIN);
  localparam logic [EW-1:0] ERR_V = EW'(LOSS_ERR);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  state_t state;
  logic [5:0] r, r_in;
  logic [2:0] fill;
  logic [MW-1:0] match;
  logic [BW-1:0] win_bits;
  logic [EW-1:0] win_errs;
  logic pred, miss;
  assign pred = r[5] ^ r[4];
  assign miss = bit_in != pred;
  assign r_in = {r[4:0], bit_in};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HUNT;
      r <= '0;
      fill <= '0;
      match <= '0;
      win_bits <= '0;
      win_errs <= '0;
      locked <= 1'b0;
      err_pulse <= 1'b0;
      sync_lost <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      sync_lost <= 1'b0;
      if (bit_valid) begin
        case (state)
          HUNT: begin
            r <= r_in;
            fill <= (fill == 3'd6) ? fill : fill + 3'd1;
            // fill reaches 6 on this bit; the all-zero register is a dead state and never accepted
            if (fill >= 3'd5 && r_in != 6'd0) begin
              state <= VERIFY;
              match <= '0;
            end
          end
          VERIFY: begin
            r <= r_in;
            if (miss) begin
              state <= HUNT;
              fill <= 3'd1;
              match <= '0;
            end else begin
              match <= match + 1'b1;
              if (match + 1'b1 == LOCK_V) begin
                state <= LOCKED;
                locked <= 1'b1;
                win_bits <= '0;
                win_errs <= '0;
              end
            end
          end
          LOCKED: begin
            r <= {r[4:0], pred};
            err_pulse <= miss;
            // loss of sync takes priority over a coincident window rollover
            if (miss && win_errs + 1'b1 == ERR_V) begin
              state <= HUNT;
              locked <= 1'b0;
              sync_lost <= 1'b1;
              fill <= '0;
              match <= '0;
              win_bits <= '0;
              win_errs <= '0;
            end else if (win_bits + 1'b1 == WIN_V) begin
              win_bits <= '0;
              win_errs <= '0;
            end else begin
              win_bits <= win_bits + 1'b1;
              win_errs <= win_errs + EW'(miss);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
`ifdef LFSR_CHK_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (reset) err_count <= '0;
    else if (bit_valid && state == LOCKED && miss && err_count != 8'hff) err_count <= err_count + 8'd1;
  end
`else
  assign err_count = 8'd0;
`endif
endmodule

// File: tb/tb_lfsr_stream_checker.sv
// tb_lfsr_stream_checker: scoreboard bench; a behavioural model queues expected outputs per driven cycle.
module tb_lfsr_stream_checker;
`ifdef LFSR_CHK_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, bit_in = 1'b0, bit_valid = 1'b0;
  logic locked, err_pulse, sync_lost, locked2, err_pulse2, sync_lost2;
  logic [7:0] err_count, err_count2;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  lfsr_stream_checker dut (.clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .locked(locked), .err_pulse(err_pulse), .sync_lost(sync_lost), .err_count(err_count));
  lfsr_stream_checker #(.LOSS_ERR(17)) dut2 (.clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .locked(locked2), .err_pulse(err_pulse2), .sync_lost(sync_lost2), .err_count(err_count2));
  typedef struct packed {logic l; logic e; logic s; logic [7:0] c;} exp_t;
  exp_t q[$];
  logic [5:0] g, m_r;
  int m_st, m_fill, m_match, m_wb, m_we, m_cnt;
  logic m_locked, m_ep, m_sl;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model(input logic rst, input logic b, input logic v);
    logic p;
    if (rst) begin
      m_r = '0; m_st = 0; m_fill = 0; m_match = 0; m_wb = 0; m_we = 0; m_cnt = 0;
      m_locked = 0; m_ep = 0; m_sl = 0;
      return;
    end
    m_ep = 0; m_sl = 0;
    if (!v) return;
    p = m_r[5] ^ m_r[4];
    if (m_st == 0) begin
      m_r = {m_r[4:0], b};
      if (m_fill < 6) m_fill++;
      if (m_fill == 6 && m_r != 0) begin m_st = 1; m_match = 0; end
    end else if (m_st == 1) begin
      m_r = {m_r[4:0], b};
      if (b != p) begin m_st = 0; m_fill = 1; m_match = 0; end
      else begin
        m_match++;
        if (m_match == 12) begin m_st = 2; m_locked = 1; m_wb = 0; m_we = 0; end
      end
    end else begin
      m_r = {m_r[4:0], p};
      m_wb++;
      if (b != p) begin
        m_ep = 1; m_we++;
        if (CNT_EN && m_cnt < 255) m_cnt++;
      end
      if (m_we == 4) begin
        m_st = 0; m_locked = 0; m_sl = 1; m_fill = 0; m_match = 0; m_wb = 0; m_we = 0;
      end else if (m_wb == 16) begin m_wb = 0; m_we = 0; end
    end
  endtask
  task automatic step(input logic rst, input logic b, input logic v);
    exp_t e;
    reset = rst; bit_in = b; bit_valid = v;
    model(rst, b, v);
    q.push_back('{m_locked, m_ep, m_sl, 8'(m_cnt)});
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("locked", 32'(locked), 32'(e.l));
    check("err_pulse", 32'(err_pulse), 32'(e.e));
    check("sync_lost", 32'(sync_lost), 32'(e.s));
    check("err_count", 32'(err_count), 32'(e.c));
  endtask
  task automatic send(input logic inv);
    logic b;
    b = g[5];
    g = {g[4:0], g[5] ^ g[4]};
    step(1'b0, b ^ inv, 1'b1);
  endtask
  task automatic clean(input int n);
    for (int i = 0; i < n; i++) send(1'b0);
  endtask
  initial begin
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("rst_locked", 32'(locked), 0);
    check("rst_cnt", 32'(err_count), 0);
    g = 6'h3f;
    clean(17);
    check("pre_lock", 32'(locked), 0);
    clean(1);
    check("lock18", 32'(locked), 1);
    send(1'b1);
    check("single_err", 32'(err_pulse), 1);
    check("single_cnt", 32'(err_count), CNT_EN ? 1 : 0);
    clean(15);
    check("still_locked", 32'(locked), 1);
    for (int i = 0; i < 4; i++) begin
      send(1'b1);
      if (i < 3) send(1'b0);
    end
    check("loss_pulse", 32'(sync_lost), 1);
    check("loss_locked", 32'(locked), 0);
    clean(17);
    check("relock_pre", 32'(locked), 0);
    clean(1);
    check("relock", 32'(locked), 1);
    check("relock_cnt", 32'(err_count), CNT_EN ? 5 : 0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1);
    check("zeros_hunt", 32'(locked), 0);
    step(1'b1, 1'b0, 1'b0);
    g = 6'h3f;
    for (int i = 0; i < 18; i++) begin
      send(1'b0);
      step(1'b0, 1'($urandom), 1'b0);
    end
    check("gapped_lock", 32'(locked), 1);
    for (int i = 0; i < 3; i++) send(1'b1);
    check("three_errs", 32'(err_count), CNT_EN ? 3 : 0);
    step(1'b1, 1'b0, 1'b1);
    check("rst_mid_locked", 32'(locked), 0);
    check("rst_mid_cnt", 32'(err_count), 0);
    g = 6'h3f;
    clean(18);
    check("sat_lock2", 32'(locked2), 1);
    for (int i = 0; i < 300; i++) send(1'b1);
    check("sat_locked2", 32'(locked2), 1);
    check("sat_cnt2", 32'(err_count2), CNT_EN ? 255 : 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
